// File: rtl/spi_sram_pkg.sv
// Shared opcodes, FSM state type and byte-select helpers for the SPI SRAM bridge.
package spi_sram_pkg;

  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_WRMR  = 8'h01;
  localparam logic [7:0] MODE_SEQ = 8'h40;

  typedef enum logic [1:0] {INIT, IDLE, SHIFT, DONE} state_t;

  // A write is only sent when its byte lanes form one contiguous run.
  function automatic logic sel_legal(input logic [3:0] s);
    case (s)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b0110, 4'b1100,
      4'b0111, 4'b1110, 4'b1111: sel_legal = 1'b1;
      default:                   sel_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] sel_lo(input logic [3:0] s);
    if (s[0])      sel_lo = 2'd0;
    else if (s[1]) sel_lo = 2'd1;
    else if (s[2]) sel_lo = 2'd2;
    else           sel_lo = 2'd3;
  endfunction

  function automatic logic [1:0] sel_hi(input logic [3:0] s);
    if (s[3])      sel_hi = 2'd3;
    else if (s[2]) sel_hi = 2'd2;
    else if (s[1]) sel_hi = 2'd1;
    else           sel_hi = 2'd0;
  endfunction

endpackage

// File: rtl/spi_sram_shifter.sv
// SPI mode-0 bit engine: shifts out up to 64 bits MSB first and keeps the last 32 received bits.
// Handshake: a one-cycle start loads tx/nbits; done is high in the final cycle of the last SCLK-high phase.
module spi_sram_shifter #(
  parameter int CLK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [6:0]  nbits,
  input  logic [63:0] tx,
  input  logic        miso,
  output logic        sclk,
  output logic        mosi,
  output logic        done,
  output logic [31:0] rx
);

  localparam int PW = $clog2(CLK_DIV + 1);

  logic          busy;
  logic [PW-1:0] phase;
  logic [6:0]    bit_left;
  logic [63:0]   tx_sr;
  logic          phase_end;

  assign phase_end = (phase == PW'(CLK_DIV - 1));
  assign done      = busy && sclk && phase_end && (bit_left == 7'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      phase    <= '0;
      bit_left <= '0;
      tx_sr    <= '0;
      rx       <= '0;
    end else if (start) begin
      busy     <= 1'b1;
      sclk     <= 1'b0;
      mosi     <= tx[63];
      tx_sr    <= {tx[62:0], 1'b0};
      bit_left <= nbits - 7'd1;
      phase    <= '0;
    end else if (busy) begin
      if (!phase_end) begin
        phase <= phase + PW'(1);
      end else begin
        phase <= '0;
        if (!sclk) begin
          // Rising SCLK: the device already put its bit out on the previous falling edge.
          sclk <= 1'b1;
          rx   <= {rx[30:0], miso};
        end else if (bit_left == 7'd0) begin
          busy <= 1'b0;
          sclk <= 1'b0;
          mosi <= 1'b0;
        end else begin
          sclk     <= 1'b0;
          mosi     <= tx_sr[63];
          tx_sr    <= {tx_sr[62:0], 1'b0};
          bit_left <= bit_left - 7'd1;
        end
      end
    end
  end

endmodule

// File: rtl/spi_sram_ctrl.sv
// Wishbone-classic to multi-device SPI SRAM bridge: FSM, chip-select decode and read-data assembly.
// Define SPI_SRAM_MODE_INIT_EN to write sequential mode (WRMR 0x40) into every device after reset.
module spi_sram_ctrl
  import spi_sram_pkg::*;
#(
  parameter  int NUM_CS  = 2,
  parameter  int DEV_AW  = 17,
  parameter  int CLK_DIV = 1,
  localparam int ADDR_W  = DEV_AW - 2 + $clog2(NUM_CS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cyc,
  input  logic [ADDR_W-1:0] adr,
  input  logic              we,
  input  logic [31:0]       dat_i,
  input  logic [3:0]        sel,
  output logic [31:0]       dat_o,
  output logic              ack,
  input  logic              spi_miso,
  output logic              spi_clk,
  output logic              spi_mosi,
  output logic [NUM_CS-1:0] spi_cs_n
);

  localparam int CS_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

  state_t           state;
  logic             hold;
  logic             skip;
  logic             start;
  logic             rd;
  logic [CS_W-1:0]  dev;
  logic [6:0]       nbits;
  logic [63:0]      tx;
  logic             done;
  logic [31:0]      rx;

  logic [CS_W-1:0]  req_dev;
  logic [1:0]       lo;
  logic [1:0]       hi;
  logic [2:0]       nbytes;
  logic [23:0]      byte_addr;
  logic [31:0]      lane_sh;
  logic [31:0]      wr_data;
  logic [6:0]       req_nbits;

`ifdef SPI_SRAM_MODE_INIT_EN
  logic [CS_W-1:0]  init_dev;
  logic             init_run;
`endif

  generate
    if (NUM_CS > 1) begin : g_dec
      assign req_dev = adr[ADDR_W-1 -: CS_W];
    end else begin : g_single
      assign req_dev = '0;
    end
  endgenerate

  // Reads always fetch a whole word starting at lane 0.
  assign lo        = we ? sel_lo(sel) : 2'd0;
  assign hi        = we ? sel_hi(sel) : 2'd3;
  assign nbytes    = {1'b0, hi} - {1'b0, lo} + 3'd1;
  assign byte_addr = 24'({adr[DEV_AW-3:0], lo});
  assign lane_sh   = dat_i >> {lo, 3'b000};
  assign wr_data   = {lane_sh[7:0], lane_sh[15:8], lane_sh[23:16], lane_sh[31:24]};
  assign req_nbits = 7'd32 + 7'({nbytes, 3'b000});

  spi_sram_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .nbits (nbits),
    .tx    (tx),
    .miso  (spi_miso),
    .sclk  (spi_clk),
    .mosi  (spi_mosi),
    .done  (done),
    .rx    (rx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
`ifdef SPI_SRAM_MODE_INIT_EN
      state    <= INIT;
      init_dev <= '0;
      init_run <= 1'b0;
`else
      state    <= IDLE;
`endif
      spi_cs_n <= '1;
      ack      <= 1'b0;
      dat_o    <= '0;
      start    <= 1'b0;
      hold     <= 1'b0;
      skip     <= 1'b0;
      rd       <= 1'b0;
      dev      <= '0;
      nbits    <= '0;
      tx       <= '0;
    end else begin
      start <= 1'b0;
      ack   <= 1'b0;
      // Chip select drops together with the first SCLK-low phase.
      if (start) spi_cs_n <= ~(NUM_CS'(1) << dev);
      case (state)
        INIT: begin
`ifdef SPI_SRAM_MODE_INIT_EN
          if (!init_run) begin
            start    <= 1'b1;
            init_run <= 1'b1;
            dev      <= init_dev;
            nbits    <= 7'd16;
            tx       <= {OP_WRMR, MODE_SEQ, 48'h0};
          end else if (done) begin
            spi_cs_n <= '1;
            init_run <= 1'b0;
            if (init_dev == CS_W'(NUM_CS - 1)) state <= IDLE;
            else init_dev <= init_dev + CS_W'(1);
          end
`else
          state <= IDLE;
`endif
        end
        IDLE: begin
          hold <= 1'b0;
          if (cyc && !hold) begin
            rd    <= !we;
            dev   <= req_dev;
            nbits <= req_nbits;
            tx    <= {(we ? OP_WRITE : OP_READ), byte_addr, (we ? wr_data : 32'h0)};
            if (we && !sel_legal(sel)) skip <= 1'b1;
            else start <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (skip) begin
            skip  <= 1'b0;
            ack   <= 1'b1;
            state <= DONE;
          end else if (done) begin
            spi_cs_n <= '1;
            ack      <= 1'b1;
            state    <= DONE;
            if (rd) dat_o <= {rx[7:0], rx[15:8], rx[23:16], rx[31:24]};
          end
        end
        DONE: begin
          hold  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_sram_ctrl.sv
// Bench for spi_sram_ctrl with two behavioural 23LC1024 models, CLK_DIV=3.
// Driver issues bus cycles and queues expectations; a negedge monitor checks every ack.
`timescale 1ns/1ps
module tb_spi_sram_ctrl;

  localparam int NUM_CS  = 2;
  localparam int DEV_AW  = 17;
  localparam int CLK_DIV = 3;
  localparam int ADDR_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cyc = 1'b0;
  logic [ADDR_W-1:0] adr = '0;
  logic              we = 1'b0;
  logic [31:0]       dat_i = '0;
  logic [3:0]        sel = '0;
  logic [31:0]       dat_o;
  logic              ack;
  logic              spi_miso;
  logic              spi_clk;
  logic              spi_mosi;
  logic [NUM_CS-1:0] spi_cs_n;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;
  bit prev_ack = 1'b0;

  logic [31:0] exp_q[$];
  bit          exp_rd_q[$];
  int          exp_cyc_q[$];

  spi_sram_ctrl #(.NUM_CS(NUM_CS), .DEV_AW(DEV_AW), .CLK_DIV(CLK_DIV)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cyc      (cyc),
    .adr      (adr),
    .we       (we),
    .dat_i    (dat_i),
    .sel      (sel),
    .dat_o    (dat_o),
    .ack      (ack),
    .spi_miso (spi_miso),
    .spi_clk  (spi_clk),
    .spi_mosi (spi_mosi),
    .spi_cs_n (spi_cs_n)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- 23LC1024 models ----------------
  for (genvar g = 0; g < NUM_CS; g++) begin : g_dev
    logic [7:0]  mem [0:131071];
    logic [7:0]  cmd, sh, obyte, mode;
    logic [23:0] maddr;
    logic [63:0] frame;
    logic        miso_b;
    int          bcnt, cs_falls, mode_at;

    initial begin
      for (int i = 0; i < 131072; i++) mem[i] = 8'h00;
      cmd = 0; sh = 0; obyte = 0; mode = 0; maddr = 0; frame = 0;
      miso_b = 0; bcnt = 0; cs_falls = 0; mode_at = 0;
    end

    always @(negedge spi_cs_n[g]) begin
      bcnt = 0; frame = 0; cmd = 0; cs_falls++;
    end

    always @(posedge spi_clk) if (spi_cs_n[g] == 1'b0) begin
      sh    = {sh[6:0], spi_mosi};
      frame = {frame[62:0], spi_mosi};
      bcnt++;
      if (bcnt == 8) cmd = sh;
      else if (bcnt <= 32 && bcnt % 8 == 0) maddr = {maddr[15:0], sh};
      else if (bcnt > 32 && bcnt % 8 == 0 && cmd == 8'h02) begin
        mem[maddr[16:0]] = sh;
        maddr = maddr + 24'd1;
      end
      if (cmd == 8'h01 && bcnt == 16) begin
        mode = sh;
        mode_at = cyc_cnt;
      end
    end

    always @(negedge spi_clk) if (spi_cs_n[g] == 1'b0 && cmd == 8'h03 && bcnt >= 32) begin
      if ((bcnt - 32) % 8 == 0) begin
        obyte = mem[maddr[16:0]];
        maddr = maddr + 24'd1;
      end
      miso_b = obyte[7 - ((bcnt - 32) % 8)];
    end
  end

  assign spi_miso = !spi_cs_n[0] ? g_dev[0].miso_b :
                    !spi_cs_n[1] ? g_dev[1].miso_b : 1'b0;

  // ---------------- driver ----------------
  task automatic bus_op(input logic w, input logic [15:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [31:0] exp_d, input int lat,
                        output int ack_at, output bit cs_seen);
    repeat (4) @(negedge clk);
    cyc = 1'b1; we = w; adr = a; dat_i = d; sel = s;
    exp_q.push_back(exp_d);
    exp_rd_q.push_back(!w);
    exp_cyc_q.push_back(lat < 0 ? -1 : cyc_cnt + 1 + lat);
    ack_at = -1;
    cs_seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (spi_cs_n != 2'b11) cs_seen = 1'b1;
      if (ack) begin
        ack_at = cyc_cnt;
        break;
      end
      adr = 16'($urandom); dat_i = $urandom; sel = 4'($urandom); we = 1'($urandom);
    end
    cyc = 1'b0;
    check("ack_seen", 64'(ack_at >= 0), 64'd1);
    if (ack_at < 0) begin
      void'(exp_q.pop_back());
      void'(exp_rd_q.pop_back());
      void'(exp_cyc_q.pop_back());
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n && ack) begin
      check("ack_width", 64'(prev_ack), 64'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got ack at cycle %0d expected none", cyc_cnt);
      end else begin
        logic [31:0] e_d;
        bit          e_rd;
        int          e_cyc;
        e_d   = exp_q.pop_front();
        e_rd  = exp_rd_q.pop_front();
        e_cyc = exp_cyc_q.pop_front();
        if (e_rd) check("read_data", 64'(dat_o), 64'(e_d));
        if (e_cyc >= 0) check("ack_cycle", 64'(cyc_cnt), 64'(e_cyc));
      end
    end
    prev_ack = ack;
  end

  // ---------------- stimulus ----------------
  initial begin
    int at;
    bit cs;
    int f0, f1;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_cs_n", 64'(spi_cs_n), 64'h3);
    check("reset_sclk", 64'(spi_clk), 64'h0);
    check("reset_mosi", 64'(spi_mosi), 64'h0);
    check("reset_ack", 64'(ack), 64'h0);
    check("reset_dat_o", 64'(dat_o), 64'h0);
    rst_n = 1'b1;

`ifdef SPI_SRAM_MODE_INIT_EN
    // A read raised during INIT must wait until both devices are in sequential mode.
    bus_op(1'b0, 16'h0000, 32'h0, 4'h0, 32'h0, -1, at, cs);
    check("init_mode0", 64'(g_dev[0].mode), 64'h40);
    check("init_mode1", 64'(g_dev[1].mode), 64'h40);
    check("init_order", 64'(g_dev[0].mode_at < g_dev[1].mode_at), 64'd1);
    check("init_before_ack", 64'(g_dev[1].mode_at < at), 64'd1);
`endif

    // Full-word write then read back: 64-bit frames.
    bus_op(1'b1, 16'h0004, 32'hDEADBEEF, 4'hF, 32'h0, 385, at, cs);
    check("t1_frame", g_dev[0].frame, 64'h02000010EFBEADDE);
    check("t1_bits", 64'(g_dev[0].bcnt), 64'd64);
    bus_op(1'b0, 16'h0004, 32'h0, 4'h0, 32'hDEADBEEF, 385, at, cs);

    // Single-lane write into lane 2.
    bus_op(1'b1, 16'h0004, 32'h00AB0000, 4'b0100, 32'h0, 241, at, cs);
    check("t2_frame", g_dev[0].frame, 64'h00000002000012AB);
    check("t2_bits", 64'(g_dev[0].bcnt), 64'd40);
    bus_op(1'b0, 16'h0004, 32'h0, 4'h0, 32'hDEABBEEF, 385, at, cs);

    // Device 1 via address MSB.
    f0 = g_dev[0].cs_falls;
    f1 = g_dev[1].cs_falls;
    bus_op(1'b1, 16'h8004, 32'h12345678, 4'hF, 32'h0, 385, at, cs);
    check("t3_cs0_idle", 64'(g_dev[0].cs_falls), 64'(f0));
    check("t3_cs1_used", 64'(g_dev[1].cs_falls), 64'(f1 + 1));
    check("t3_frame1", g_dev[1].frame, 64'h0200001078563412);
    check("t3_dev0_kept", 64'({g_dev[0].mem[19], g_dev[0].mem[18], g_dev[0].mem[17], g_dev[0].mem[16]}),
          64'hDEABBEEF);
    bus_op(1'b0, 16'h8004, 32'h0, 4'h0, 32'h12345678, 385, at, cs);

    // Illegal byte selects: immediate ack, no SPI traffic.
    bus_op(1'b1, 16'h0004, 32'hFFFFFFFF, 4'b0101, 32'h0, 1, at, cs);
    check("t4_sel0101_no_cs", 64'(cs), 64'd0);
    bus_op(1'b1, 16'h0004, 32'hFFFFFFFF, 4'b0000, 32'h0, 1, at, cs);
    check("t4_sel0000_no_cs", 64'(cs), 64'd0);
    check("t4_mem_kept", 64'({g_dev[0].mem[19], g_dev[0].mem[18], g_dev[0].mem[17], g_dev[0].mem[16]}),
          64'hDEABBEEF);

    // Reset in the middle of a read.
    repeat (4) @(negedge clk);
    cyc = 1'b1; we = 1'b0; adr = 16'h0004; sel = 4'h0;
    for (int i = 0; i < 2000 && g_dev[0].bcnt != 20; i++) @(negedge clk);
    check("t5_reached_bit20", 64'(g_dev[0].bcnt), 64'd20);
    #2 rst_n = 1'b0;
    #1;
    check("t5_cs_n", 64'(spi_cs_n), 64'h3);
    check("t5_sclk", 64'(spi_clk), 64'h0);
    check("t5_ack", 64'(ack), 64'h0);
    check("t5_dat_o", 64'(dat_o), 64'h0);
    cyc = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
`ifdef SPI_SRAM_MODE_INIT_EN
    bus_op(1'b0, 16'h0004, 32'h0, 4'h0, 32'hDEABBEEF, -1, at, cs);
`else
    bus_op(1'b0, 16'h0004, 32'h0, 4'h0, 32'hDEABBEEF, 385, at, cs);
`endif

    repeat (5) @(negedge clk);
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
